// File: rtl/cpu_pkg.sv
// Shared encodings for the PC/redirect path: next-PC source select, redirect FSM states,
// and the sequential fetch increment.
package cpu_pkg;

  typedef enum logic [1:0] {
    SEQ = 2'b00,
    BR  = 2'b01,
    JMP = 2'b10,
    JR  = 2'b11
  } pc_src_t;

  typedef enum logic {
    RUN     = 1'b0,
    JR_WAIT = 1'b1
  } state_t;

  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/pc_src_arbiter.sv
// Combinational next-PC source arbiter: branch > jr > jump > sequential.
// Also produces the flush requests and the jr wait-entry condition.
module pc_src_arbiter
  import cpu_pkg::*;
(
  input  logic    i_branch_taken,
  input  logic    i_jr,
  input  logic    i_jr_valid,
  input  logic    i_jump,
  input  logic    i_stall,
  input  state_t  i_state,
  output pc_src_t o_pc_src,
  output logic    o_flush_if_id,
  output logic    o_flush_id_ex,
  output logic    o_wait_enter
);

  always_comb begin
    o_pc_src      = SEQ;
    o_flush_if_id = 1'b0;
    o_flush_id_ex = 1'b0;
    o_wait_enter  = 1'b0;
    if (i_branch_taken) begin
      // EX-stage branch is the oldest instruction; it beats stalls and pending jr.
      o_pc_src      = BR;
      o_flush_if_id = 1'b1;
      o_flush_id_ex = 1'b1;
    end else if (i_state == JR_WAIT) begin
      // The waiting jr is already captured; only its forwarded target is awaited.
      if (i_jr_valid) begin
        o_pc_src      = JR;
        o_flush_if_id = 1'b1;
      end
    end else if (!i_stall) begin
      if (i_jr) begin
        if (i_jr_valid) begin
          o_pc_src      = JR;
          o_flush_if_id = 1'b1;
        end else begin
          o_wait_enter = 1'b1;
        end
      end else if (i_jump) begin
        o_pc_src      = JMP;
        o_flush_if_id = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// PC register owner: applies branch/jr/jump redirects, waits for forwarded jr targets,
// tracks misaligned targets and counts applied redirects.
module pc_redirect_ctrl
  import cpu_pkg::*;
#(
  parameter int                WIDTH    = 32,
  parameter logic [WIDTH-1:0]  RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             jr_i,
  input  logic [WIDTH-1:0] jr_target_i,
  input  logic             jr_target_valid_i,
  input  logic             jump_i,
  input  logic [WIDTH-1:0] jump_target_i,
  input  logic             branch_taken_i,
  input  logic [WIDTH-1:0] branch_target_i,
  output logic [WIDTH-1:0] pc_o,
  output logic             flush_if_id_o,
  output logic             flush_id_ex_o,
  output logic             stall_req_o,
  output logic             misalign_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [WIDTH-1:0] r_pc;
  state_t           r_state;
  logic             r_misalign;
  logic [CNT_W-1:0] r_cnt;

  pc_src_t          w_src;
  logic             w_flush_if_id;
  logic             w_flush_id_ex;
  logic             w_wait_enter;
  logic [WIDTH-1:0] w_target;
  logic             w_load;
  logic             w_hold;
  logic             w_misal;

  pc_src_arbiter u_arb (
    .i_branch_taken (branch_taken_i),
    .i_jr           (jr_i),
    .i_jr_valid     (jr_target_valid_i),
    .i_jump         (jump_i),
    .i_stall        (stall_i),
    .i_state        (r_state),
    .o_pc_src       (w_src),
    .o_flush_if_id  (w_flush_if_id),
    .o_flush_id_ex  (w_flush_id_ex),
    .o_wait_enter   (w_wait_enter)
  );

  always_comb begin
    w_target = '0;
    unique case (w_src)
      BR:      w_target = branch_target_i;
      JMP:     w_target = jump_target_i;
      JR:      w_target = jr_target_i;
      default: w_target = '0;
    endcase
  end

  assign w_load  = (w_src != SEQ);
  assign w_hold  = stall_i || w_wait_enter || (r_state == JR_WAIT);
  assign w_misal = w_load && (w_target[1:0] != 2'b00);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_pc       <= RESET_PC;
      r_state    <= RUN;
      r_misalign <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_load)
        r_pc <= {w_target[WIDTH-1:2], 2'b00};
      else if (!w_hold)
        r_pc <= r_pc + WIDTH'(PC_INC);
      if (w_load)
        r_state <= RUN;
      else if (w_wait_enter)
        r_state <= JR_WAIT;
      if (w_misal)
        r_misalign <= 1'b1;
      if (w_load)
        r_cnt <= sat_inc(r_cnt);
    end
  end

  // Combinational requests are suppressed while reset is asserted.
  assign flush_if_id_o  = rst_i & w_flush_if_id;
  assign flush_id_ex_o  = rst_i & w_flush_id_ex;
  assign stall_req_o    = rst_i & (r_state == JR_WAIT);
  assign pc_o           = r_pc;
  assign misalign_o     = r_misalign;
  assign redirect_cnt_o = r_cnt;

endmodule
